mux4_1_sync: RTL and testbench
==============================

Name: mux4_1_sync

Overview:
- Parameterised 4:1 data multiplexer with a registered output stage, load enable and output-valid flag.
- Selects one of four Width-bit inputs by a 2-bit select. Presents the result one clock later together with the select that produced it.
- Sits as a generic datapath steering element. Downstream logic samples ou1 when ou_valid is high.

Parameters:
- Width, 4, bit width of every data input and of ou1 (legal range 1..64).
- REGISTERED, 1, 1 = output registered (1-cycle latency); 0 = combinational bypass (0-cycle latency).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- en  input  1  load enable; result captured only when high
- in1  input  Width  data input, selected by sel=2'b00
- in2  input  Width  data input, selected by sel=2'b01
- in3  input  Width  data input, selected by sel=2'b10
- in4  input  Width  data input, selected by sel=2'b11
- sel  input  2  select code
- ou1  output  Width  selected data
- ou_valid  output  1  ou1 holds a freshly loaded value
- sel_q  output  2  select code that produced current ou1

Behaviour:
- One clock; reset is synchronous and active-low: rst_n sampled only on rising clk edge, no asynchronous path.
- Select decode is a full case, no priority, no latch:
  - 00 -> in1, 01 -> in2, 10 -> in3, 11 -> in4.
  - A default branch is required and drives in4.
- REGISTERED=1, on each rising clk edge:
  - rst_n=0: ou1 <= 0, sel_q <= 2'b00, ou_valid <= 0. This overrides en.
  - rst_n=1, en=1: ou1 <= mux(sel), sel_q <= sel, ou_valid <= 1.
  - rst_n=1, en=0: ou1 and sel_q hold, ou_valid <= 0.
  - Latency: ou1 reflects sel/inputs sampled at the previous edge.
  - Input or sel changes between edges have no effect on outputs.
  - Reset mid-stream: the next edge with rst_n=0 clears all outputs, regardless of en or sel.
  - First edge after reset release with en=1: load normally, ou_valid=1.
- REGISTERED=0:
  - ou1 = rst_n ? mux(sel) : 0; ou_valid = rst_n & en; sel_q = rst_n ? sel : 2'b00.
  - Purely combinational; clk unused.
- Back-to-back loads with en held high: a new result every cycle, ou_valid stays high.
- All outputs are exactly Width/1/2 bits. No truncation or extension inside the mux.

Decomposition:
- Shared package mux4_1_pkg:
  - localparams SEL_IN1=2'b00, SEL_IN2=2'b01, SEL_IN3=2'b10, SEL_IN4=2'b11.
  - typedef sel_t (2-bit).
- One sub-module, mux4_core:
  - Purely combinational 4:1 mux, parameter Width.
  - Ports in1..in4, sel, y.
- The top instantiates mux4_core and adds the output register, valid flag, sel_q capture and the REGISTERED generate branch.

Test Plan:
- Width=4, REGISTERED=1, in1..in4 = 1,2,3,4, en=1, sel stepped 0,1,2,3 one per cycle -> one cycle after each step, ou1 = 0001, 0010, 0011, 0100, sel_q = sel, ou_valid=1.
- rst_n=0 for 2 cycles with en=1, sel=2 -> ou1=0000, sel_q=00, ou_valid=0. First edge after release gives ou1=0011.
- Load sel=3 (ou1=0100), then en=0 and change sel to 0 and in4 to 9 -> ou1 stays 0100, sel_q stays 11, ou_valid drops to 0 the next cycle.
- Assert rst_n=0 mid-stream while en=1 and sel toggling -> outputs clear on that same edge, no residual value appears afterwards.
- REGISTERED=0, rst_n=1, en=1, sweep sel 0..3 with inputs 1..4 -> ou1 follows with zero latency (1, 2, 3, 4). Driving rst_n=0 forces ou1=0 immediately.
- Width=8, random inputs, 200 random sel/en cycles -> ou1 matches the reference model mux(sel) of the prior enabled cycle, with exact ou_valid timing.

Source files
------------

// File: rtl/mux4_1_pkg.sv
// rtl/mux4_1_pkg.sv - shared select codes and types for the 4:1 steering mux
package mux4_1_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_IN1 = 2'b00;
    localparam sel_t SEL_IN2 = 2'b01;
    localparam sel_t SEL_IN3 = 2'b10;
    localparam sel_t SEL_IN4 = 2'b11;

endpackage

// File: rtl/mux4_core.sv
// rtl/mux4_core.sv - purely combinational 4:1 data selector
module mux4_core
    import mux4_1_pkg::*;
#(
    parameter int Width = 4
) (
    input  logic [Width-1:0] in1,
    input  logic [Width-1:0] in2,
    input  logic [Width-1:0] in3,
    input  logic [Width-1:0] in4,
    input  sel_t             sel,
    output logic [Width-1:0] y
);

    always_comb begin
        y = in4;
        case (sel)
            SEL_IN1: y = in1;
            SEL_IN2: y = in2;
            SEL_IN3: y = in3;
            SEL_IN4: y = in4;
            default: y = in4;
        endcase
    end

endmodule

// File: rtl/mux4_1_sync.sv
// rtl/mux4_1_sync.sv - 4:1 mux with optional output register, load enable and valid flag
module mux4_1_sync
    import mux4_1_pkg::*;
#(
    parameter int Width      = 4,
    parameter bit REGISTERED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [Width-1:0] in1,
    input  logic [Width-1:0] in2,
    input  logic [Width-1:0] in3,
    input  logic [Width-1:0] in4,
    input  sel_t             sel,
    output logic [Width-1:0] ou1,
    output logic             ou_valid,
    output sel_t             sel_q
);

    logic [Width-1:0] mux_y;

    mux4_core #(.Width(Width)) u_core (
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .in4 (in4),
        .sel (sel),
        .y   (mux_y)
    );

    generate
        if (REGISTERED) begin : g_reg
            // ou1 and sel_q hold across disabled cycles; only the valid flag drops.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ou1      <= '0;
                    sel_q    <= SEL_IN1;
                    ou_valid <= 1'b0;
                end else if (en) begin
                    ou1      <= mux_y;
                    sel_q    <= sel;
                    ou_valid <= 1'b1;
                end else begin
                    ou_valid <= 1'b0;
                end
            end
        end else begin : g_comb
            logic unused_clk;
            assign unused_clk = clk;
            assign ou1        = rst_n ? mux_y : '0;
            assign ou_valid   = rst_n & en;
            assign sel_q      = rst_n ? sel : SEL_IN1;
        end
    endgenerate

endmodule

// File: tb/tb_mux4_1_sync.sv
// tb/tb_mux4_1_sync.sv - scoreboard bench for registered and bypass configurations
module tb_mux4_1_sync;

    typedef struct {
        logic [3:0] ou4;
        logic [7:0] ou8;
        logic       valid;
        logic [1:0] selq;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] sel = 2'b00;
    logic [7:0] d8 [4];
    logic [3:0] d4 [4];

    logic [3:0] ou_r4, ou_c4;
    logic [7:0] ou_r8;
    logic       v_r4, v_r8, v_c4;
    logic [1:0] sq_r4, sq_r8, sq_c4;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;

    logic [7:0] m_ou = '0;
    logic [1:0] m_sel = '0;

    always #5 clk = ~clk;

    mux4_1_sync #(.Width(4), .REGISTERED(1'b1)) dut_r4 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in1(d4[0]), .in2(d4[1]), .in3(d4[2]), .in4(d4[3]), .sel(sel),
        .ou1(ou_r4), .ou_valid(v_r4), .sel_q(sq_r4)
    );

    mux4_1_sync #(.Width(8), .REGISTERED(1'b1)) dut_r8 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in1(d8[0]), .in2(d8[1]), .in3(d8[2]), .in4(d8[3]), .sel(sel),
        .ou1(ou_r8), .ou_valid(v_r8), .sel_q(sq_r8)
    );

    mux4_1_sync #(.Width(4), .REGISTERED(1'b0)) dut_c4 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in1(d4[0]), .in2(d4[1]), .in3(d4[2]), .in4(d4[3]), .sel(sel),
        .ou1(ou_c4), .ou_valid(v_c4), .sel_q(sq_c4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Applies one cycle of stimulus; the registered expectation is queued for the monitor.
    task automatic step(input bit r, input bit e, input logic [1:0] s,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
        exp_t x;
        logic [7:0] pick;
        @(negedge clk);
        rst_n = r; en = e; sel = s;
        d8[0] = a; d8[1] = b; d8[2] = c; d8[3] = d;
        for (int i = 0; i < 4; i++) d4[i] = d8[i][3:0];
        pick = d8[s];
        if (!r) begin
            m_ou = '0; m_sel = 2'b00;
        end else if (e) begin
            m_ou = pick; m_sel = s;
        end
        x.ou8 = m_ou;
        x.ou4 = m_ou[3:0];
        x.valid = r && e;
        x.selq = m_sel;
        sb.push_back(x);
        #1;
        check("comb_ou1", ou_c4, r ? pick[3:0] : 4'h0);
        check("comb_valid", v_c4, r && e);
        check("comb_sel_q", sq_c4, r ? s : 2'b00);
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check("reg4_ou1", ou_r4, x.ou4);
            check("reg4_valid", v_r4, x.valid);
            check("reg4_sel_q", sq_r4, x.selq);
            check("reg8_ou1", ou_r8, x.ou8);
            check("reg8_valid", v_r8, x.valid);
            check("reg8_sel_q", sq_r8, x.selq);
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            d8[i] = '0;
            d4[i] = '0;
        end
        // reset held with en high, then first load after release
        step(0, 1, 2, 1, 2, 3, 4);
        step(0, 1, 2, 1, 2, 3, 4);
        step(1, 1, 2, 1, 2, 3, 4);
        for (int s = 0; s < 4; s++) step(1, 1, s[1:0], 1, 2, 3, 4);
        // hold while disabled, inputs and sel changing
        step(1, 1, 3, 1, 2, 3, 4);
        step(1, 0, 0, 1, 2, 3, 9);
        step(1, 0, 1, 5, 6, 7, 9);
        // reset mid-stream, then no residual value
        step(1, 1, 1, 8'h11, 8'h22, 8'h33, 8'h44);
        step(1, 1, 2, 8'h11, 8'h22, 8'h33, 8'h44);
        step(0, 1, 1, 8'h11, 8'h22, 8'h33, 8'h44);
        step(1, 0, 3, 8'h11, 8'h22, 8'h33, 8'h44);
        step(1, 0, 2, 8'h11, 8'h22, 8'h33, 8'h44);
        for (int n = 0; n < 200; n++) begin
            step($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)),
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
